// File: rtl/pkt_rr_arbiter.sv
// pkt_rr_arbiter: round-robin packet arbiter with whole-packet grant lock and beat-count watchdog
module pkt_rr_arbiter #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int MAX_PKT_LEN = 64
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_REQ-1:0]          req_valid,
  input  logic [NUM_REQ-1:0]          req_head,
  input  logic [NUM_REQ-1:0]          req_tail,
  input  logic [NUM_REQ*DATA_W-1:0]   req_data,
  output logic [NUM_REQ-1:0]          req_ready,
  output logic                        out_valid,
  output logic                        out_head,
  output logic                        out_tail,
  output logic [DATA_W-1:0]           out_data,
  input  logic                        out_ready,
  output logic [NUM_REQ-1:0]          grant,
  output logic                        busy,
  output logic                        err_trunc,
  output logic                        err_stray
);
  localparam int PW = NUM_REQ > 1 ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(MAX_PKT_LEN);
  typedef enum logic {IDLE, XFER} state_t;
  state_t             state_q, state_d;
  logic [NUM_REQ-1:0] grant_q, grant_d, cand;
  logic [PW-1:0]      ptr_q, ptr_d, gidx_q, gidx_d, pick;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic               found, last;
  assign grant = grant_q;
  assign busy  = state_q == XFER;
  assign last  = cnt_q == CW'(MAX_PKT_LEN - 1);
  // first head-bearing requester after the rr pointer; descending scan so the nearest one wins
  always_comb begin
    cand  = req_valid & req_head;
    found = 1'b0;
    pick  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      if (cand[(int'(ptr_q) + k) % NUM_REQ]) begin
        found = 1'b1;
        pick  = PW'((int'(ptr_q) + k) % NUM_REQ);
      end
    end
  end
  // IDLE drops strays and arbitrates; XFER muxes the owner through and ends on a real or forced tail
  always_comb begin
    state_d   = state_q;
    grant_d   = grant_q;
    ptr_d     = ptr_q;
    gidx_d    = gidx_q;
    cnt_d     = cnt_q;
    out_valid = 1'b0;
    out_head  = 1'b0;
    out_tail  = 1'b0;
    out_data  = req_data[gidx_q*DATA_W +: DATA_W];
    req_ready = '0;
    err_trunc = 1'b0;
    err_stray = 1'b0;
    if (state_q == IDLE) begin
      req_ready = req_valid & ~req_head & {NUM_REQ{~reset}};
      err_stray = |req_ready;
      if (found) begin
        state_d = XFER;
        grant_d = NUM_REQ'(1) << pick;
        gidx_d  = pick;
      end
    end else begin
      out_valid = req_valid[gidx_q];
      out_head  = req_head[gidx_q];
      out_tail  = req_tail[gidx_q] | last;
      req_ready = grant_q & {NUM_REQ{out_ready}};
      if (out_valid && out_ready) begin
        err_trunc = last & ~req_tail[gidx_q];
        cnt_d     = out_tail ? '0 : cnt_q + 1'b1;
        if (out_tail) begin
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = gidx_q;
        end
      end
    end
  end
  // state registers; reset aborts any packet in flight without emitting a tail
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= PW'(NUM_REQ - 1);
      gidx_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      gidx_q  <= gidx_d;
      cnt_q   <= cnt_d;
    end
  end
endmodule

// File: tb/tb_pkt_rr_arbiter.sv
// tb_pkt_rr_arbiter: directed and randomized checks of pkt_rr_arbiter against a packet-level model
module tb_pkt_rr_arbiter;
  localparam int N  = 4;
  localparam int DW = 16;
  localparam int ML = 4;
  logic            clk = 1'b0;
  logic            reset;
  logic [N-1:0]    req_valid, req_head, req_tail, req_ready, grant;
  logic [N*DW-1:0] req_data;
  logic            out_valid, out_head, out_tail, out_ready, busy, err_trunc, err_stray;
  logic [DW-1:0]   out_data;
  int n_chk = 0;
  int n_fail = 0;
  int m_owner, m_ptr, m_cnt, n_owner, n_ptr, n_cnt;

  pkt_rr_arbiter #(.NUM_REQ(N), .DATA_W(DW), .MAX_PKT_LEN(ML)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_head(req_head), .req_tail(req_tail), .req_data(req_data),
    .req_ready(req_ready),
    .out_valid(out_valid), .out_head(out_head), .out_tail(out_tail), .out_data(out_data),
    .out_ready(out_ready),
    .grant(grant), .busy(busy), .err_trunc(err_trunc), .err_stray(err_stray)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic h, input logic t, input logic [DW-1:0] d);
    req_valid[i] = v;
    req_head[i]  = h;
    req_tail[i]  = t;
    req_data[i*DW +: DW] = d;
  endtask

  task automatic clear_req();
    req_valid = '0;
    req_head  = '0;
    req_tail  = '0;
    req_data  = '0;
  endtask

  task automatic model_reset();
    m_owner = -1;
    m_ptr   = N - 1;
    m_cnt   = 0;
  endtask

  // compare outputs mid-cycle against the model and compute the model's post-edge state
  task automatic settle();
    logic [N-1:0] erdy;
    logic ev, et, acc, tr, st;
    int c;
    @(negedge clk);
    n_owner = m_owner;
    n_ptr   = m_ptr;
    n_cnt   = m_cnt;
    tr = 1'b0;
    et = 1'b0;
    if (m_owner < 0) begin
      erdy = req_valid & ~req_head;
      st = |erdy;
      ev = 1'b0;
      for (int k = 1; k <= N; k++) begin
        c = (m_ptr + k) % N;
        if (n_owner < 0 && req_valid[c] && req_head[c]) n_owner = c;
      end
      chk("grant", grant, 0);
    end else begin
      st   = 1'b0;
      ev   = req_valid[m_owner];
      et   = req_tail[m_owner] || (m_cnt == ML - 1);
      erdy = out_ready ? N'(1) << m_owner : '0;
      acc  = ev && out_ready;
      tr   = acc && (m_cnt == ML - 1) && !req_tail[m_owner];
      if (acc && et) begin
        n_owner = -1;
        n_ptr   = m_owner;
        n_cnt   = 0;
      end else if (acc) n_cnt = m_cnt + 1;
      chk("grant", grant, 32'(N'(1) << m_owner));
    end
    chk("busy", busy, m_owner >= 0);
    chk("out_valid", out_valid, ev);
    chk("req_ready", req_ready, erdy);
    chk("err_trunc", err_trunc, tr);
    chk("err_stray", err_stray, st);
    if (ev) begin
      chk("out_head", out_head, req_head[m_owner]);
      chk("out_tail", out_tail, et);
      chk("out_data", out_data, req_data[m_owner*DW +: DW]);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    m_owner = n_owner;
    m_ptr   = n_ptr;
    m_cnt   = n_cnt;
    #1;
  endtask

  initial begin
    reset = 1'b1;
    out_ready = 1'b0;
    clear_req();
    req_valid = '1;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_grant", grant, 0);
    chk("rst_busy", busy, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_err_trunc", err_trunc, 0);
    chk("rst_err_stray", err_stray, 0);
    clear_req();
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk);
    #1;
    // single requester, 3-beat packet with a 5-cycle stall on the middle beat
    out_ready = 1'b1;
    set_req(1, 1, 1, 0, 16'hA1);
    settle(); chk("t2_arb_outv", out_valid, 0); tick();
    settle(); chk("t2_grant", grant, 4'b0010); chk("t2_d1", out_data, 16'hA1); chk("t2_h1", out_head, 1); tick();
    set_req(1, 1, 0, 0, 16'hA2);
    out_ready = 1'b0;
    repeat (5) begin
      settle(); chk("t4_hold_data", out_data, 16'hA2); chk("t4_rdy", req_ready, 0); chk("t4_grant", grant, 4'b0010); tick();
    end
    out_ready = 1'b1;
    settle(); chk("t2_d2", out_data, 16'hA2); chk("t2_h2", out_head, 0); tick();
    set_req(1, 1, 0, 1, 16'hA3);
    settle(); chk("t2_d3", out_data, 16'hA3); chk("t2_t3", out_tail, 1); tick();
    clear_req();
    settle(); chk("t2_grant_end", grant, 0); tick();
    // watchdog: req3 never sends a tail
    set_req(3, 1, 1, 0, 16'h30);
    settle(); tick();
    settle(); chk("t5_grant", grant, 4'b1000); tick();
    for (int b = 2; b <= 6; b++) begin
      set_req(3, 1, 0, 0, DW'(16'h30 + b));
      settle();
      if (b == 4) begin chk("t5_force_tail", out_tail, 1); chk("t5_trunc", err_trunc, 1); end
      if (b >= 5) begin chk("t5_stray", err_stray, 1); chk("t5_stray_busy", busy, 0); end
      tick();
    end
    clear_req();
    settle(); tick();
    // asynchronous reset on beat 2 of a req2 packet
    set_req(2, 1, 1, 0, 16'hC1);
    settle(); tick();
    settle(); chk("t6_grant", grant, 4'b0100); tick();
    set_req(2, 1, 0, 0, 16'hC2);
    settle();
    #2 reset = 1'b1;
    #1;
    chk("t6_async_grant", grant, 0);
    chk("t6_async_busy", busy, 0);
    chk("t6_async_outv", out_valid, 0);
    @(posedge clk);
    model_reset();
    #1 reset = 1'b0;
    clear_req();
    for (int i = 0; i < N; i++) set_req(i, 1, 1, 0, DW'(16'hD0 + i));
    settle(); tick();
    settle(); chk("t6_first_win", grant, 4'b0001); tick();
    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < N; i++)
        set_req(i, $urandom_range(0, 3) != 0, $urandom_range(0, 9) < 3, $urandom_range(0, 9) < 2, DW'($urandom));
      out_ready = $urandom_range(0, 3) != 0;
      settle();
      tick();
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
